// File: rtl/usb_cdc_byte_fifo.sv
// First-word-fall-through byte FIFO between the USB CDC outport and inport,
// with optional upper-casing on write and line-buffered release toward the host.
module usb_cdc_byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [1:0]            mode_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  rx_accept_o,
    output logic                  tx_valid_o,
    output logic [7:0]            tx_data_o,
    input  logic                  tx_accept_i,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic [15:0]           rx_bytes_o,
    output logic [15:0]           tx_bytes_o
);
    localparam int                    DEPTH   = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   ZERO_C  = (DEPTH_LOG2 + 1)'(0);
    localparam logic [DEPTH_LOG2:0]   ONE_C   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_0   = (DEPTH_LOG2)'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_1   = (DEPTH_LOG2)'(1);

    function automatic logic [7:0] to_upper(input logic [7:0] b, input logic en);
        logic [7:0] res;
        if (en && (b >= 8'h61) && (b <= 8'h7A)) begin
            res = b - 8'h20;
        end else begin
            res = b;
        end
        return res;
    endfunction

    function automatic logic is_eol(input logic [7:0] b);
        return (b == 8'h0D) || (b == 8'h0A);
    endfunction

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   r_eol_cnt;
    logic [1:0]            r_mode;
    logic [15:0]           r_rx_bytes;
    logic [15:0]           r_tx_bytes;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [7:0]            w_wdata;
    logic                  w_eol_in;
    logic                  w_eol_out;
    logic [DEPTH_LOG2:0]   w_count_nxt;
    logic [DEPTH_LOG2:0]   w_eol_nxt;

    assign w_full      = (r_count == DEPTH_C);
    assign w_empty     = (r_count == ZERO_C);
    assign rx_accept_o = !rst_i && !flush_i && !w_full;
    // A full FIFO releases even without a terminator so the core cannot deadlock.
    assign tx_valid_o  = !rst_i && !w_empty &&
                         (!r_mode[1] || (r_eol_cnt != ZERO_C) || w_full);
    assign tx_data_o   = r_mem[r_rd_ptr];
    assign w_push      = rx_valid_i && rx_accept_o;
    assign w_pop       = tx_valid_o && tx_accept_i;
    assign w_wdata     = to_upper(rx_data_i, r_mode[0]);
    assign w_eol_in    = w_push && is_eol(w_wdata);
    assign w_eol_out   = w_pop && is_eol(tx_data_o);
    assign level_o     = rst_i ? ZERO_C : r_count;
    assign rx_bytes_o  = r_rx_bytes;
    assign tx_bytes_o  = r_tx_bytes;

    // Next occupancy and stored-terminator count from this cycle's push/pop.
    always_comb begin
        w_count_nxt = r_count;
        w_eol_nxt   = r_eol_cnt;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + ONE_C;
            2'b01:   w_count_nxt = r_count - ONE_C;
            default: w_count_nxt = r_count;
        endcase
        case ({w_eol_in, w_eol_out})
            2'b10:   w_eol_nxt = r_eol_cnt + ONE_C;
            2'b01:   w_eol_nxt = r_eol_cnt - ONE_C;
            default: w_eol_nxt = r_eol_cnt;
        endcase
    end

    // Byte storage; only written on an accepted push.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    // Pointers, occupancy, mode register and traffic counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr   <= PTR_0;
            r_rd_ptr   <= PTR_0;
            r_count    <= ZERO_C;
            r_eol_cnt  <= ZERO_C;
            r_mode     <= 2'b00;
            r_rx_bytes <= 16'h0000;
            r_tx_bytes <= 16'h0000;
        end else begin
            r_mode <= mode_i;
            if (w_push) begin
                r_rx_bytes <= r_rx_bytes + 16'h0001;
            end
            if (w_pop) begin
                r_tx_bytes <= r_tx_bytes + 16'h0001;
            end
            // Flush discards contents but a same-cycle pop has still been counted.
            if (flush_i) begin
                r_wr_ptr  <= PTR_0;
                r_rd_ptr  <= PTR_0;
                r_count   <= ZERO_C;
                r_eol_cnt <= ZERO_C;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_1;
                end
                r_count   <= w_count_nxt;
                r_eol_cnt <= w_eol_nxt;
            end
        end
    end
endmodule
